// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue controller for the ALU execute block. An instruction is
// accepted in IDLE, decoded against the register file in DECODE, handed to the
// ALU in EXEC and retired as a register writeback or a branch resolution in WB.
module alu_issue_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  // Instruction handshake from fetch
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  // Register-file read ports
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  // ALU initiator side
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic        alu_imm_signal,
  output logic [20:0] alu_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  // Retirement
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic [15:0] branch_offset,
  output logic        illegal
);

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBeq   = 6'b000100;

  // R-type function codes
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  // ALU control encodings
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSll = 4'b1110;
  localparam logic [3:0] AluSrl = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWb
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q;

  // Fields of the latched instruction word
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        is_rtype;
  logic        is_beq;
  logic [4:0]  dst_addr;

  // Decode results, valid while in DECODE
  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic        dec_imm_sig;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign imm16    = instr_q[15:0];
  assign is_rtype = (opcode == OpRtype);
  assign is_beq   = (opcode == OpBeq);
  assign dst_addr = is_rtype ? instr_q[15:11] : instr_q[20:16];

  // Register-file addresses come straight from the latched word; they are zero
  // after reset because the latch is.
  assign rs_addr = instr_q[25:21];
  assign rt_addr = instr_q[20:16];

  assign instr_ready = (state_q == StIdle) && rst_n;

  // Strobes are derived from state and gated by reset so that no pulse can
  // appear while the sequencer is being cleared.
  assign illegal      = rst_n && (state_q == StDecode) && !dec_legal;
  assign wb_en        = rst_n && (state_q == StWb) && !is_beq && (dst_addr != 5'd0);
  assign branch_valid = rst_n && (state_q == StWb) && is_beq;

  // Instruction decode: ALU control, operand selection and legality
  always_comb begin
    dec_legal   = 1'b0;
    dec_ctrl    = AluAnd;
    dec_imm_sig = 1'b0;
    dec_a       = rs_data;
    dec_b       = rt_data;
    if (is_rtype) begin
      unique case (funct)
        FnAnd: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluAnd;
        end
        FnOr: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluOr;
        end
        FnAdd: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluAdd;
        end
        FnSub: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluSub;
        end
        // Shifts operate on rt; the amount travels in alu_imm[10:6]
        FnSll: begin
          dec_legal   = 1'b1;
          dec_ctrl    = AluSll;
          dec_imm_sig = 1'b1;
          dec_a       = rt_data;
          dec_b       = '0;
        end
        FnSrl: begin
          dec_legal   = 1'b1;
          dec_ctrl    = AluSrl;
          dec_imm_sig = 1'b1;
          dec_a       = rt_data;
          dec_b       = '0;
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_imm_sig = 1'b1;
      unique case (opcode)
        OpAddi: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluAdd;
          dec_b     = {{16{imm16[15]}}, imm16};
        end
        OpAndi: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluAnd;
          dec_b     = {16'h0000, imm16};
        end
        OpOri: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluOr;
          dec_b     = {16'h0000, imm16};
        end
        // BEQ compares by subtraction and reads the ALU zero flag
        OpBeq: begin
          dec_legal = 1'b1;
          dec_ctrl  = AluSub;
          dec_b     = rt_data;
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (instr_valid && instr_ready) state_d = StDecode;
      StDecode: state_d = dec_legal ? StExec : StIdle;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, instruction latch, ALU input registers and retirement registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      instr_q        <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_control    <= '0;
      alu_imm_signal <= 1'b0;
      alu_imm        <= '0;
      wb_addr        <= '0;
      wb_data        <= '0;
      branch_taken   <= 1'b0;
      branch_offset  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && instr_valid) begin
        instr_q <= instr;
      end
      // ALU inputs only move on a legal DECODE->EXEC edge
      if (state_q == StDecode && dec_legal) begin
        alu_a          <= dec_a;
        alu_b          <= dec_b;
        alu_control    <= dec_ctrl;
        alu_imm_signal <= dec_imm_sig;
        alu_imm        <= instr_q[20:0];
      end
      // Capture the ALU response; outputs only change when a strobe follows
      if (state_q == StExec) begin
        if (is_beq) begin
          branch_taken  <= alu_zero;
          branch_offset <= imm16;
        end else if (dst_addr != 5'd0) begin
          wb_addr <= dst_addr;
          wb_data <= alu_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: a driver issues instructions and
// pushes the expected retirement event; a negedge monitor pops and compares.
module tb_alu_issue_sequencer;

  localparam int EvNone = 0;
  localparam int EvWb   = 1;
  localparam int EvBr   = 2;
  localparam int EvIll  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        taken;
    logic [15:0] off;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        sig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        alu_imm_signal;
  logic [20:0] alu_imm;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch_valid, branch_taken;
  logic [15:0] branch_offset;
  logic        illegal;

  logic [31:0] regs [32];
  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  alu_issue_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_control    (alu_control),
    .alu_imm_signal (alu_imm_signal),
    .alu_imm        (alu_imm),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .branch_valid   (branch_valid),
    .branch_taken   (branch_taken),
    .branch_offset  (branch_offset),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  // Stand-in for the ALU block
  always_comb begin
    alu_result = 32'h0;
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1110: alu_result = alu_a << alu_imm[10:6];
      4'b1100: alu_result = alu_a >> alu_imm[10:6];
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                        input logic [5:0] fn);
    logic [31:0] w;
    w = {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    logic [31:0] w;
    w = {op, 5'(rs), 5'(rt), imm};
    return w;
  endfunction

  // Reference: what the instruction should do, from the instruction-set rules
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] rv,
                                 input logic [31:0] tv);
    exp_t        e;
    logic [31:0] sx, zx;
    logic [4:0]  dst;
    bit          legal, br;
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0000, w[15:0]};
    legal = 1'b1;
    br = 1'b0;
    e.cyc = 0; e.a = rv; e.b = tv; e.ctrl = 4'h0; e.sig = 1'b0;
    e.data = 32'h0; e.taken = 1'b0; e.off = w[15:0];
    if (w[31:26] == 6'h00) begin
      dst = w[15:11];
      case (w[5:0])
        6'h24: begin e.ctrl = 4'b0000; e.data = rv & tv; end
        6'h25: begin e.ctrl = 4'b0001; e.data = rv | tv; end
        6'h20: begin e.ctrl = 4'b0010; e.data = rv + tv; end
        6'h22: begin e.ctrl = 4'b0110; e.data = rv - tv; end
        6'h00: begin
          e.ctrl = 4'b1110; e.sig = 1'b1; e.a = tv; e.b = 0; e.data = tv << w[10:6];
        end
        6'h02: begin
          e.ctrl = 4'b1100; e.sig = 1'b1; e.a = tv; e.b = 0; e.data = tv >> w[10:6];
        end
        default: legal = 1'b0;
      endcase
    end else begin
      dst = w[20:16];
      e.sig = 1'b1;
      case (w[31:26])
        6'h08: begin e.ctrl = 4'b0010; e.b = sx; e.data = rv + sx; end
        6'h0c: begin e.ctrl = 4'b0000; e.b = zx; e.data = rv & zx; end
        6'h0d: begin e.ctrl = 4'b0001; e.b = zx; e.data = rv | zx; end
        6'h04: begin e.ctrl = 4'b0110; e.b = tv; br = 1'b1; e.taken = (rv == tv); end
        default: legal = 1'b0;
      endcase
    end
    e.addr = dst;
    if (!legal)          e.kind = EvIll;
    else if (br)         e.kind = EvBr;
    else if (dst == 5'd0) e.kind = EvNone;
    else                 e.kind = EvWb;
    return e;
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 0);
    chk({tag, "_strobes"}, 32'({wb_en, branch_valid, illegal}), 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_ctl_imm"}, 32'({alu_control, alu_imm_signal, alu_imm}), 0);
    chk({tag, "_addrs"}, 32'({wb_addr, rs_addr, rt_addr}), 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_branch"}, 32'({branch_taken, branch_offset}), 0);
  endtask

  // Issue one word; optionally assert reset during its EXEC cycle
  task automatic issue(input logic [31:0] w, input bit rst_in_exec);
    exp_t e;
    int   n;
    int   acc;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 1);
      instr_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    e = model(w, regs[w[25:21]], regs[w[20:16]]);
    e.cyc = (e.kind == EvIll) ? acc : acc + 2;
    if (e.kind != EvNone) q.push_back(e);
    @(negedge clk);  // DECODE
    instr_valid = 1'b0;
    chk("decode_busy", 32'(instr_ready), 0);
    chk("decode_rs_addr", 32'(rs_addr), 32'(w[25:21]));
    chk("decode_rt_addr", 32'(rt_addr), 32'(w[20:16]));
    if (e.kind == EvIll) begin
      @(negedge clk);
      chk("ready_after_illegal", 32'(instr_ready), 1);
      return;
    end
    @(negedge clk);  // EXEC
    chk("exec_alu_a", alu_a, e.a);
    chk("exec_alu_b", alu_b, e.b);
    chk("exec_alu_control", 32'(alu_control), 32'(e.ctrl));
    chk("exec_alu_imm_signal", 32'(alu_imm_signal), 32'(e.sig));
    chk("exec_alu_imm", 32'(alu_imm), 32'(w[20:0]));
    if (rst_in_exec) begin
      rst_n = 1'b0;
      q.delete();
      instr = $urandom;
      instr_valid = 1'b1;
      @(negedge clk);
      chk_cleared("midrst");
      @(negedge clk);
      chk("midrst_hold_ready", 32'(instr_ready), 0);
      instr_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_release_ready", 32'(instr_ready), 1);
      return;
    end
    @(negedge clk);  // WB
    @(negedge clk);
    chk("ready_after_op", 32'(instr_ready), 1);
  endtask

  // Monitor: every strobe must match the oldest expected event at its cycle
  always @(negedge clk) begin
    if (mon_en) begin
      int   n;
      int   obs;
      exp_t e;
      n = int'(wb_en) + int'(branch_valid) + int'(illegal);
      if (n > 1) chk("strobes_exclusive", 32'(n), 1);
      if (n >= 1) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'({wb_en, branch_valid, illegal}), 0);
        end else begin
          e = q.pop_front();
          obs = wb_en ? EvWb : (branch_valid ? EvBr : EvIll);
          chk("strobe_kind", 32'(obs), 32'(e.kind));
          chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          if (obs == EvWb && e.kind == EvWb) begin
            chk("wb_addr", 32'(wb_addr), 32'(e.addr));
            chk("wb_data", wb_data, e.data);
          end
          if (obs == EvBr && e.kind == EvBr) begin
            chk("branch_taken", 32'(branch_taken), 32'(e.taken));
            chk("branch_offset", 32'(branch_offset), 32'(e.off));
          end
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        e = q.pop_front();
        chk("missing_strobe", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  rfn [6];
    logic [5:0]  iop [3];
    logic [31:0] w;
    logic [5:0]  x;
    int          k, rs, rt, rd;
    rfn = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h00, 6'h02};
    iop = '{6'h08, 6'h0c, 6'h0d};
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'h0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    repeat (2) @(negedge clk);
    instr_valid = 1'b1;  // offered during reset: must not be accepted
    @(negedge clk);
    chk_cleared("reset");
    instr_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed cases
    regs[1] = 32'd5; regs[2] = 32'd7;
    issue(32'h00221820, 1'b0);                       // ADD r3,r1,r2
    regs[1] = 32'd0;
    issue(enc_i(6'h08, 1, 4, 16'hFFFF), 1'b0);       // ADDI r4,r1,-1
    regs[2] = 32'd1;
    issue(enc_r(0, 2, 5, 4, 6'h00), 1'b0);           // SLL r5,r2,4
    regs[1] = 32'd9; regs[2] = 32'd9;
    issue(enc_i(6'h04, 1, 2, 16'h0010), 1'b0);       // BEQ taken
    regs[2] = 32'd8;
    issue(enc_i(6'h04, 1, 2, 16'h0010), 1'b0);       // BEQ not taken
    issue(enc_r(1, 2, 0, 0, 6'h20), 1'b0);           // ADD r0: no writeback
    issue(32'hFC000000, 1'b0);                       // illegal opcode
    regs[1] = 32'd3; regs[2] = 32'd4;
    issue(enc_r(1, 2, 6, 0, 6'h20), 1'b1);           // reset during EXEC

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      regs[$urandom_range(1, 31)] = $urandom;
      regs[$urandom_range(1, 31)] = 32'($urandom_range(0, 3));
      k = $urandom_range(0, 11);
      rs = $urandom_range(0, 31);
      rt = $urandom_range(0, 31);
      rd = $urandom_range(0, 31);
      if (k < 6) begin
        w = enc_r(rs, rt, rd, $urandom_range(0, 31), rfn[k]);
      end else if (k < 9) begin
        w = enc_i(iop[k-6], rs, rt, 16'($urandom));
      end else if (k == 9) begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        w = enc_i(6'h04, rs, rt, 16'($urandom));
      end else if (k == 10) begin
        x = 6'($urandom);
        while (x == 6'h24 || x == 6'h25 || x == 6'h20 || x == 6'h22 || x == 6'h00 ||
               x == 6'h02) x = 6'($urandom);
        w = enc_r(rs, rt, rd, 0, x);
      end else begin
        x = 6'($urandom);
        while (x == 6'h00 || x == 6'h08 || x == 6'h0c || x == 6'h0d || x == 6'h04)
          x = 6'($urandom);
        w = {x, 26'($urandom)};
      end
      issue(w, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
# alu_issue_sequencer

Multi-cycle instruction issue controller for the `ALU` execute block. It accepts 32-bit MIPS-format instruction words over a valid/ready handshake and reads operands from the register file. It drives the ALU operand, control and immediate inputs, then captures `ALU_Result`/`Zero` and emits a register writeback or a branch resolution. It is the initiator side of the ALU interface and sits between fetch and the register file.

## Interface
Parameters: none (widths fixed by the ALU interface).

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `instr_valid`  in  1  instruction word offered
- `instr_ready`  out  1  sequencer can accept
- `instr`  in  32  instruction word
- `rs_addr`  out  5  register-file read address A (`instr[25:21]`)
- `rt_addr`  out  5  register-file read address B (`instr[20:16]`)
- `rs_data`  in  32  combinational read data for `rs_addr`
- `rt_data`  in  32  combinational read data for `rt_addr`
- `alu_a`  out  32  to ALU `A`
- `alu_b`  out  32  to ALU `B`
- `alu_control`  out  4  to ALU `ALU_Control`
- `alu_imm_signal`  out  1  to ALU `imm_signal`
- `alu_imm`  out  21  to ALU `imm` (`instr[20:0]`)
- `alu_result`  in  32  from ALU `ALU_Result`
- `alu_zero`  in  1  from ALU `Zero`
- `wb_en`  out  1  one-cycle register write strobe
- `wb_addr`  out  5  destination register
- `wb_data`  out  32  write data
- `branch_valid`  out  1  one-cycle BEQ resolution strobe
- `branch_taken`  out  1  BEQ outcome, valid with `branch_valid`
- `branch_offset`  out  16  `instr[15:0]`, valid with `branch_valid`
- `illegal`  out  1  one-cycle strobe for an undecodable instruction

## Operation
- FSM states: IDLE, DECODE, EXEC, WB. Only IDLE accepts instructions.
  - IDLE → DECODE on `instr_valid && instr_ready`. The instruction word is latched on that edge.
  - DECODE → EXEC on the next edge for a legal instruction.
  - DECODE → IDLE for an illegal instruction, with `illegal` high for that one cycle.
  - EXEC → WB on the next edge.
  - WB → IDLE on the next edge.
- `instr_ready` = (state == IDLE) && `rst_n`.
- `rs_addr`/`rt_addr` are driven from the latched word during DECODE. `rs_data`/`rt_data` are sampled at the DECODE→EXEC edge.
- Decode, R-type (opcode `000000`) by funct:
  - `100100` AND → `0000`
  - `100101` OR → `0001`
  - `100000` ADD → `0010`
  - `100010` SUB → `0110`
  - `000000` SLL → `1110`
  - `000010` SRL → `1100`
  - Any other funct is illegal.
- Decode, I-type by opcode:
  - `001000` ADDI → `0010`, B = sign-extended `instr[15:0]`
  - `001100` ANDI → `0000`, B = zero-extended
  - `001101` ORI → `0001`, B = zero-extended
  - `000100` BEQ → `0110`, B = `rt_data`
  - Any other opcode is illegal.
- Operands:
  - Default: `alu_a` = `rs_data`; `alu_b` = `rt_data` for R-type, immediate for I-type.
  - Shifts: `alu_a` = `rt_data`, `alu_b` = 0. The shift amount reaches the ALU through `alu_imm[10:6]`.
- `alu_imm_signal` = 1 for I-type and shifts; 0 for AND/OR/ADD/SUB R-type.
- `alu_a`, `alu_b`, `alu_control`, `alu_imm`, `alu_imm_signal` are registered and all update on the same DECODE→EXEC edge. They hold their values until the next legal DECODE→EXEC edge.
- At the EXEC→WB edge, `alu_result` and `alu_zero` are captured into internal registers.
- In WB:
  - R-type: `wb_en` = 1 with `wb_addr` = `instr[15:11]`.
  - I-type ALU ops: `wb_en` = 1 with `wb_addr` = `instr[20:16]`.
  - Destination 0: `wb_en` stays 0.
  - BEQ: `wb_en` = 0; `branch_valid` = 1 and `branch_taken` = captured zero.
- `wb_data` = captured result. `wb_addr`, `wb_data`, `branch_taken`, `branch_offset` hold between strobes.

## Timing
- Reset state (edge with `rst_n` = 0): FSM in IDLE.
  - All data outputs are 0, including `alu_*`, `wb_*`, `branch_*`, `rs_addr`, `rt_addr`.
  - Strobes `wb_en`, `branch_valid`, `illegal` are 0.
  - `instr_ready` is 0 while `rst_n` = 0.
- Latency: accept at edge N.
  - DECODE occupies cycle N+1.
  - ALU inputs are valid from edge N+2 (EXEC).
  - Result is captured at edge N+3; `wb_en`/`branch_valid` are high during cycle N+3.
  - `instr_ready` returns at N+4.
- Throughput: one instruction per 4 cycles; an illegal instruction costs 2 cycles.
- `instr_valid` held while not ready: no acceptance and no side effects; the word must stay stable until accepted.
- Reset mid-operation: any state returns to IDLE at the next edge with `rst_n` = 0. The in-flight instruction is dropped, and no `wb_en`, `branch_valid` or `illegal` pulse follows.
- Strobes are exactly one cycle wide and mutually exclusive.

## Test plan
- ADD r3,r1,r2 (`instr`=`0x00221820`, r1 = 5, r2 = 7) → `alu_control`=`0010` in EXEC; `wb_en` pulse, `wb_addr`=3, `wb_data`=12, at accept+3.
- ADDI r4,r1,-1 (r1 = 0) → `alu_b`=`0xFFFFFFFF`, `alu_imm_signal`=1; `wb_data`=`0xFFFFFFFF`, `wb_addr`=4.
- SLL r5,r2,4 (r2 = 1) → `alu_a`=1, `alu_control`=`1110`, `alu_imm[10:6]`=4; `wb_data`=16.
- BEQ r1,r2,0x0010 with r1 = r2 = 9, then with r2 = 8 → `branch_valid`, `branch_taken`=1 then 0; `branch_offset`=`0x0010`; `wb_en` never asserted.
- ADD r0,r1,r2, then opcode `111111` → no `wb_en` for the first; `illegal` one-cycle pulse at accept+1 for the second, and `instr_ready` high again at accept+2.
- `instr_valid` held through a busy sequence, with `rst_n` low during EXEC → sequencer in IDLE with all outputs 0 at the next edge, no WB strobe, and no acceptance while `rst_n` = 0.
